// File: rtl/wb_i2c_sequencer.sv
// Wishbone master that turns single-byte I2C requests into I2CMB register
// sequences (CSR/DPR/CMDR). It waits on the core interrupt between commands.
module wb_i2c_sequencer #(
    parameter int          ADDR_WIDTH     = 2,
    parameter int          DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_rw_i,
    input  logic [3:0]            req_bus_i,
    input  logic [6:0]            req_addr_i,
    input  logic [7:0]            req_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [7:0]            rsp_data_o,
    output logic [2:0]            rsp_status_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i,
    input  logic                  irq_i
);

    typedef enum logic [3:0] {
        S_ENABLE, S_IDLE, S_SETBUS, S_START, S_ADDR,
        S_DATA, S_READ_DPR, S_STOP, S_RESP
    } state_t;

    typedef enum logic [1:0] {
        PH_DPR, PH_CMD, PH_WAIT, PH_RDCMD
    } phase_t;

    localparam logic [ADDR_WIDTH-1:0] A_CSR  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_DPR  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_CMDR = ADDR_WIDTH'(2);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_OK   = 3'b000;
    localparam logic [2:0] ST_NAK  = 3'b001;
    localparam logic [2:0] ST_AL   = 3'b010;
    localparam logic [2:0] ST_ERR  = 3'b011;
    localparam logic [2:0] ST_TMO  = 3'b100;

    state_t                state_q, state_d;
    phase_t                phase_q, phase_d;
    logic                  enabled_q, enabled_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rw_q, rw_d;
    logic [3:0]            bus_q, bus_d;
    logic [6:0]            addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [7:0]            rsp_data_q, rsp_data_d;
    logic [2:0]            rsp_status_q, rsp_status_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;

    logic                  acc_go;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_adr;
    logic [7:0]            acc_byte;
    logic [7:0]            dpr_wdata;
    logic [7:0]            cmd_code;
    logic [7:0]            cmdr_rd;
    state_t                next_step;
    logic                  go_resp;

    // First register access of each transfer step.
    function automatic phase_t entry_phase(input state_t s, input logic rw);
        case (s)
            S_SETBUS, S_ADDR, S_READ_DPR: entry_phase = PH_DPR;
            S_DATA:                       entry_phase = rw ? PH_CMD : PH_DPR;
            default:                      entry_phase = PH_CMD;
        endcase
    endfunction

    always_comb begin
        case (state_q)
            S_SETBUS: dpr_wdata = {4'b0000, bus_q};
            S_ADDR:   dpr_wdata = {addr_q, rw_q};
            S_DATA:   dpr_wdata = data_q;
            default:  dpr_wdata = 8'h00;
        endcase
        case (state_q)
            S_SETBUS: cmd_code = 8'h06;
            S_START:  cmd_code = 8'h04;
            S_ADDR:   cmd_code = 8'h01;
            S_DATA:   cmd_code = rw_q ? 8'h03 : 8'h01;
            default:  cmd_code = 8'h05;
        endcase
        case (state_q)
            S_SETBUS: next_step = S_START;
            S_START:  next_step = S_ADDR;
            S_ADDR:   next_step = S_DATA;
            S_DATA:   next_step = rw_q ? S_READ_DPR : S_STOP;
            default:  next_step = S_RESP;
        endcase
    end

    assign cmdr_rd = dat_i[7:0];

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        enabled_d    = enabled_q;
        req_ready_d  = req_ready_q;
        rw_d         = rw_q;
        bus_d        = bus_q;
        addr_d       = addr_q;
        data_d       = data_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        tmo_d        = tmo_q;
        acc_go       = 1'b0;
        acc_we       = 1'b0;
        acc_adr      = '0;
        acc_byte     = '0;
        go_resp      = 1'b0;

        // The bus cycle ends on the ack edge; the next access can only be
        // launched from a cycle where cyc_q is low, giving one idle cycle.
        if (cyc_q && ack_i) begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            we_d  = 1'b0;
            adr_d = '0;
            dat_d = '0;
        end

        case (state_q)
            S_ENABLE: begin
                if (!cyc_q) begin
                    acc_go   = 1'b1;
                    acc_we   = 1'b1;
                    acc_adr  = A_CSR;
                    acc_byte = 8'hC0;
                end else if (ack_i) begin
                    enabled_d   = 1'b1;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            S_IDLE: begin
                if (req_valid_i && req_ready_q && enabled_q) begin
                    rw_d         = req_rw_i;
                    bus_d        = req_bus_i;
                    addr_d       = req_addr_i;
                    data_d       = req_data_i;
                    req_ready_d  = 1'b0;
                    rsp_data_d   = '0;
                    rsp_status_d = ST_OK;
                    state_d      = S_SETBUS;
                    phase_d      = PH_DPR;
                end
            end

            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d  = 1'b0;
                    rsp_data_d   = '0;
                    rsp_status_d = '0;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end

            default: begin
                case (phase_q)
                    PH_DPR: begin
                        if (!cyc_q) begin
                            acc_go   = 1'b1;
                            acc_we   = (state_q != S_READ_DPR);
                            acc_adr  = A_DPR;
                            acc_byte = dpr_wdata;
                        end else if (ack_i) begin
                            if (state_q == S_READ_DPR) begin
                                rsp_data_d = dat_i[7:0];
                                state_d    = S_STOP;
                            end
                            phase_d = PH_CMD;
                        end
                    end

                    PH_CMD: begin
                        if (!cyc_q) begin
                            acc_go   = 1'b1;
                            acc_we   = 1'b1;
                            acc_adr  = A_CMDR;
                            acc_byte = cmd_code;
                        end else if (ack_i) begin
                            phase_d = PH_WAIT;
                            tmo_d   = '0;
                        end
                    end

                    PH_WAIT: begin
                        if (irq_i) begin
                            phase_d = PH_RDCMD;
                        end else if (TIMEOUT_CYCLES != 0) begin
                            if (tmo_q == TMO_LAST) begin
                                rsp_status_d = ST_TMO;
                                go_resp      = 1'b1;
                            end else begin
                                tmo_d = tmo_q + TMO_W'(1);
                            end
                        end
                    end

                    default: begin
                        if (!cyc_q) begin
                            acc_go  = 1'b1;
                            acc_adr = A_CMDR;
                        end else if (ack_i) begin
                            // ERR > AL > NAK; a NAK on the final read byte is expected.
                            if (cmdr_rd[4]) begin
                                rsp_status_d = ST_ERR;
                                go_resp      = 1'b1;
                            end else if (cmdr_rd[5]) begin
                                rsp_status_d = ST_AL;
                                go_resp      = 1'b1;
                            end else if (cmdr_rd[6] &&
                                         (state_q == S_ADDR ||
                                          (state_q == S_DATA && !rw_q))) begin
                                rsp_status_d = ST_NAK;
                                state_d      = S_STOP;
                                phase_d      = PH_CMD;
                            end else if (next_step == S_RESP) begin
                                go_resp = 1'b1;
                            end else begin
                                state_d = next_step;
                                phase_d = entry_phase(next_step, rw_q);
                            end
                        end
                    end
                endcase
            end
        endcase

        if (go_resp) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
        end

        if (acc_go) begin
            cyc_d = 1'b1;
            stb_d = 1'b1;
            we_d  = acc_we;
            adr_d = acc_adr;
            dat_d = acc_we ? DATA_WIDTH'(acc_byte) : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_ENABLE;
            phase_q      <= PH_DPR;
            enabled_q    <= 1'b0;
            req_ready_q  <= 1'b0;
            rw_q         <= 1'b0;
            bus_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            enabled_q    <= enabled_d;
            req_ready_q  <= req_ready_d;
            rw_q         <= rw_d;
            bus_q        <= bus_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            tmo_q        <= tmo_d;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_status_o = rsp_status_q;
    assign cyc_o        = cyc_q;
    assign stb_o        = stb_q;
    assign we_o         = we_q;
    assign adr_o        = adr_q;
    assign dat_o        = dat_q;

endmodule

// File: tb/tb_wb_i2c_sequencer.sv
// Scoreboard bench for wb_i2c_sequencer: an I2CMB slave model answers the
// Wishbone accesses while a monitor checks accesses and responses in order.
module tb_wb_i2c_sequencer;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       req_valid_i;
    logic       req_ready_o;
    logic       req_rw_i;
    logic [3:0] req_bus_i;
    logic [6:0] req_addr_i;
    logic [7:0] req_data_i;
    logic       rsp_valid_o;
    logic       rsp_ready_i;
    logic [7:0] rsp_data_o;
    logic [2:0] rsp_status_o;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i;
    logic       ack_i;
    logic       irq_i;

    always #5 clk = ~clk;

    wb_i2c_sequencer #(
        .ADDR_WIDTH    (2),
        .DATA_WIDTH    (8),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_rw_i    (req_rw_i),
        .req_bus_i   (req_bus_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_status_o(rsp_status_o),
        .cyc_o       (cyc_o),
        .stb_o       (stb_o),
        .we_o        (we_o),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .dat_i       (dat_i),
        .ack_i       (ack_i),
        .irq_i       (irq_i)
    );

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_wb[$];   // {we, adr, dat}
    logic [10:0] exp_rsp[$];  // {data, status}
    logic [7:0]  cmdr_q[$];   // CMDR readback overrides, default 0x80
    logic [7:0]  dpr_rd_val;
    bit          suppress_irq;
    int          irq_cnt;
    bit          tmo_counting;
    int          wait_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] wbe(input logic we, input logic [1:0] adr, input logic [7:0] dat);
        return {we, adr, dat};
    endfunction

    task automatic exp_cmd(input logic [7:0] c);
        exp_wb.push_back(wbe(1'b1, 2'd2, c));
        exp_wb.push_back(wbe(1'b0, 2'd2, 8'h00));
    endtask

    task automatic exp_dpr(input logic [7:0] d);
        exp_wb.push_back(wbe(1'b1, 2'd1, d));
    endtask

    task automatic exp_resp(input logic [7:0] d, input logic [2:0] s);
        exp_rsp.push_back({d, s});
    endtask

    task automatic do_req(input logic rw, input logic [3:0] bus, input logic [6:0] addr, input logic [7:0] data);
        int n = 0;
        @(posedge clk); #1;
        while (!req_ready_o && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready", {31'b0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        req_rw_i    = rw;
        req_bus_i   = bus;
        req_addr_i  = addr;
        req_data_i  = data;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (exp_wb.size() == 0 && exp_rsp.size() == 0) break;
        end
        chk(name, exp_wb.size() + exp_rsp.size(), 0);
        repeat (5) @(posedge clk);
    endtask

    // Slave model + monitor
    initial begin
        logic [10:0] act;
        logic [10:0] e;
        ack_i = 1'b0; dat_i = '0; irq_i = 1'b0;
        irq_cnt = 0; tmo_counting = 0; wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                ack_i = 1'b0; dat_i = '0; irq_i = 1'b0;
                irq_cnt = 0; tmo_counting = 0;
                continue;
            end
            if (tmo_counting) begin
                if (rsp_valid_o) begin
                    chk("timeout_wait_cycles", wait_cnt, 20);
                    tmo_counting = 0;
                end else if (!cyc_o) begin
                    wait_cnt++;
                end
            end
            if (rsp_valid_o && rsp_ready_i) begin
                if (exp_rsp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: got data %0h status %0h expected none", rsp_data_o, rsp_status_o);
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_data", rsp_data_o, e[10:3]);
                    chk("rsp_status", rsp_status_o, e[2:0]);
                end
            end
            if (irq_cnt > 0) begin
                irq_cnt--;
                if (irq_cnt == 0) irq_i = 1'b1;
            end
            if (ack_i) begin
                ack_i = 1'b0;
                dat_i = '0;
                chk("wb_cyc_drop", {31'b0, cyc_o}, 0);
            end else if (cyc_o && stb_o) begin
                act = {we_o, adr_o, dat_o};
                if (exp_wb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected: got %0h expected none", act);
                end else begin
                    chk("wb_access", act, exp_wb.pop_front());
                end
                ack_i = 1'b1;
                if (adr_o == 2'd2 && we_o) begin
                    if (!suppress_irq) irq_cnt = 10;
                    else if (dat_o == 8'h06) begin
                        tmo_counting = 1;
                        wait_cnt = 0;
                    end
                end
                if (adr_o == 2'd2 && !we_o) begin
                    dat_i = (cmdr_q.size() != 0) ? cmdr_q.pop_front() : 8'h80;
                    irq_i = 1'b0;
                end
                if (adr_o == 2'd1 && !we_o) dat_i = dpr_rd_val;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b0; req_valid_i = 1'b0; req_rw_i = 1'b0; req_bus_i = '0;
        req_addr_i = '0; req_data_i = '0; rsp_ready_i = 1'b1;
        dpr_rd_val = 8'h00; suppress_irq = 0;
        repeat (3) @(posedge clk); #1;
        chk("rst_cyc", {31'b0, cyc_o}, 0);
        chk("rst_stb", {31'b0, stb_o}, 0);
        chk("rst_adr_dat", {22'b0, adr_o, dat_o}, 0);
        chk("rst_req_ready", {31'b0, req_ready_o}, 0);
        chk("rst_rsp", {20'b0, rsp_valid_o, rsp_data_o, rsp_status_o}, 0);
        exp_wb.push_back(wbe(1'b1, 2'd0, 8'hC0));
        rst_i = 1'b1;

        // write bus=3 addr=0x22 data=0xA5
        exp_dpr(8'h03); exp_cmd(8'h06); exp_cmd(8'h04);
        exp_dpr(8'h44); exp_cmd(8'h01); exp_dpr(8'hA5); exp_cmd(8'h01); exp_cmd(8'h05);
        exp_resp(8'h00, 3'b000);
        do_req(1'b0, 4'd3, 7'h22, 8'hA5);
        drain("t1_write");

        // read bus=0 addr=0x50
        dpr_rd_val = 8'h3C;
        exp_dpr(8'h00); exp_cmd(8'h06); exp_cmd(8'h04);
        exp_dpr(8'hA1); exp_cmd(8'h01); exp_cmd(8'h03);
        exp_wb.push_back(wbe(1'b0, 2'd1, 8'h00));
        exp_cmd(8'h05);
        exp_resp(8'h3C, 3'b000);
        do_req(1'b1, 4'd0, 7'h50, 8'h00);
        drain("t2_read");

        // address NAK
        cmdr_q.push_back(8'h80); cmdr_q.push_back(8'h80); cmdr_q.push_back(8'hC0);
        exp_dpr(8'h01); exp_cmd(8'h06); exp_cmd(8'h04);
        exp_dpr(8'h20); exp_cmd(8'h01); exp_cmd(8'h05);
        exp_resp(8'h00, 3'b001);
        do_req(1'b0, 4'd1, 7'h10, 8'h55);
        drain("t3_nak");

        // arbitration lost on START
        cmdr_q.push_back(8'h80); cmdr_q.push_back(8'hA0);
        exp_dpr(8'h02); exp_cmd(8'h06); exp_cmd(8'h04);
        exp_resp(8'h00, 3'b010);
        do_req(1'b0, 4'd2, 7'h33, 8'h11);
        drain("t4_al");
        repeat (20) @(posedge clk);

        // timeout after SETBUS command
        suppress_irq = 1;
        exp_dpr(8'h05);
        exp_wb.push_back(wbe(1'b1, 2'd2, 8'h06));
        exp_resp(8'h00, 3'b100);
        do_req(1'b0, 4'd5, 7'h0F, 8'h00);
        drain("t5_timeout");
        repeat (20) @(posedge clk);
        suppress_irq = 0;

        // response backpressure; requests offered meanwhile must be ignored
        rsp_ready_i = 1'b0;
        exp_dpr(8'h03); exp_cmd(8'h06); exp_cmd(8'h04);
        exp_dpr(8'h44); exp_cmd(8'h01); exp_dpr(8'hA5); exp_cmd(8'h01); exp_cmd(8'h05);
        exp_resp(8'h00, 3'b000);
        do_req(1'b0, 4'd3, 7'h22, 8'hA5);
        for (int i = 0; i < 2000 && !rsp_valid_o; i++) begin
            @(posedge clk); #1;
        end
        chk("bp_rsp_valid", {31'b0, rsp_valid_o}, 1);
        req_valid_i = 1'b1; req_bus_i = 4'd7; req_addr_i = 7'h7F; req_data_i = 8'hEE;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("bp_hold", {19'b0, rsp_valid_o, rsp_data_o, rsp_status_o, req_ready_o},
                {19'b0, 1'b1, 8'h00, 3'b000, 1'b0});
        end
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        drain("t6_backpressure");

        // reset during ADDR DPR access
        exp_dpr(8'h04); exp_cmd(8'h06); exp_cmd(8'h04);
        do_req(1'b0, 4'd4, 7'h11, 8'h22);
        for (int i = 0; i < 1000 && !(cyc_o && we_o && adr_o == 2'd1 && dat_o == 8'h22); i++) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_addr_reached", {31'b0, cyc_o}, 1);
        rst_i = 1'b0;
        #1;
        chk("rst_async_cyc", {29'b0, cyc_o, stb_o, we_o}, 0);
        chk("rst_async_rsp", {30'b0, rsp_valid_o, req_ready_o}, 0);
        chk("rst_pending_wb", exp_wb.size(), 0);
        cmdr_q.delete();
        repeat (3) @(posedge clk); #1;
        exp_wb.push_back(wbe(1'b1, 2'd0, 8'hC0));
        rst_i = 1'b1;
        drain("t7_reenable");
        repeat (20) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
